// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops bytes from a one-cycle-latency synchronous FIFO and
// packs LANES of them into one output word. The first byte lands in the least
// significant lane. The packed word is then held under a valid/ready handshake.
// A one-cycle flush request forces out a partially filled word.
// LANES is expected to be at least 2 and at most 7, so that word_bytes fits in 3 bits.
module fifo_word_packer #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_data,
    output logic                   fifo_rd,
    input  logic                   flush,
    output logic [WIDTH*LANES-1:0] word_out,
    output logic [2:0]             word_bytes,
    output logic                   word_valid,
    input  logic                   word_ready
);

    // Counter width is just wide enough to hold LANES; it saturates there.
    localparam int CW = $clog2(LANES + 1);
    localparam logic [CW:0]   LANES_EXT = LANES[CW:0];
    localparam logic [CW-1:0] LANES_CNT = LANES[CW-1:0];

    typedef enum logic [0:0] {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_next_s;
    logic [CW-1:0]          cnt_inc_s;
    logic                   pend_r;
    logic                   pend_next_s;
    logic                   flush_req_r;
    logic                   flush_req_next_s;
    logic [WIDTH*LANES-1:0] word_r;
    logic [WIDTH*LANES-1:0] word_next_s;
    logic [2:0]             bytes_r;
    logic [2:0]             bytes_next_s;
    logic                   valid_r;
    logic                   valid_next_s;
    logic                   rd_s;
    logic [CW:0]            inflight_s;

    // Pop only while filling, with data upstream, no flush waiting, and a free lane
    // that is not already claimed by an in-flight read.
    always_comb begin
        rd_s       = 1'b0;
        inflight_s = {1'b0, cnt_r} + {{CW{1'b0}}, pend_r};
        if (!rst && (state_r == FILL) && !fifo_empty && !flush_req_r
            && (inflight_s < LANES_EXT)) begin
            rd_s = 1'b1;
        end else begin
            rd_s = 1'b0;
        end
    end

    // Next-state and next-datapath logic for the FILL/OUT machine.
    always_comb begin
        next_state_s     = state_r;
        cnt_next_s       = cnt_r;
        pend_next_s      = rd_s;
        flush_req_next_s = flush_req_r;
        word_next_s      = word_r;
        bytes_next_s     = bytes_r;
        valid_next_s     = valid_r;
        cnt_inc_s        = cnt_r + {{(CW-1){1'b0}}, 1'b1};

        case (state_r)
            FILL: begin
                if (pend_r && (cnt_r != LANES_CNT)) begin
                    // Byte popped last cycle is on fifo_data now: write it into lane cnt.
                    for (int k = 0; k < LANES; k++) begin
                        if (cnt_r == k[CW-1:0]) begin
                            word_next_s[k*WIDTH +: WIDTH] = fifo_data;
                        end else begin
                            word_next_s[k*WIDTH +: WIDTH] = word_r[k*WIDTH +: WIDTH];
                        end
                    end
                    cnt_next_s = cnt_inc_s;
                    if (cnt_inc_s == LANES_CNT) begin
                        next_state_s     = OUT;
                        valid_next_s     = 1'b1;
                        bytes_next_s     = 3'(LANES_CNT);
                        flush_req_next_s = 1'b0;
                    end else begin
                        flush_req_next_s = flush_req_r | flush;
                    end
                end else if (flush_req_r) begin
                    // No read is in flight, so the partial word is complete.
                    if (cnt_r != {CW{1'b0}}) begin
                        next_state_s     = OUT;
                        valid_next_s     = 1'b1;
                        bytes_next_s     = 3'(cnt_r);
                        flush_req_next_s = 1'b0;
                    end else begin
                        flush_req_next_s = 1'b0;
                    end
                end else begin
                    flush_req_next_s = flush;
                end
            end
            OUT: begin
                // Filling is frozen while the word is held. Flush is ignored here.
                pend_next_s      = 1'b0;
                flush_req_next_s = 1'b0;
                if (word_ready) begin
                    next_state_s = FILL;
                    cnt_next_s   = {CW{1'b0}};
                    word_next_s  = {(WIDTH*LANES){1'b0}};
                    bytes_next_s = 3'b000;
                    valid_next_s = 1'b0;
                end else begin
                    next_state_s = OUT;
                end
            end
            default: begin
                next_state_s     = FILL;
                cnt_next_s       = {CW{1'b0}};
                pend_next_s      = 1'b0;
                flush_req_next_s = 1'b0;
                word_next_s      = {(WIDTH*LANES){1'b0}};
                bytes_next_s     = 3'b000;
                valid_next_s     = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath registers: lane counter, pending-read flag, flush latch and the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= {CW{1'b0}};
            pend_r      <= 1'b0;
            flush_req_r <= 1'b0;
            word_r      <= {(WIDTH*LANES){1'b0}};
            bytes_r     <= 3'b000;
            valid_r     <= 1'b0;
        end else begin
            cnt_r       <= cnt_next_s;
            pend_r      <= pend_next_s;
            flush_req_r <= flush_req_next_s;
            word_r      <= word_next_s;
            bytes_r     <= bytes_next_s;
            valid_r     <= valid_next_s;
        end
    end

    assign fifo_rd    = rd_s;
    assign word_out   = word_r;
    assign word_bytes = bytes_r;
    assign word_valid = valid_r;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer. A queue stands in for the upstream
// FIFO. Every popped byte is remembered in order. Each emitted word must equal
// the bytes popped since the previous word, placed first-byte-lowest and zero-padded.
`timescale 1ns/1ps
module tb_fifo_word_packer;
    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int WW    = WIDTH * LANES;

    logic             clk;
    logic             rst;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd;
    logic             flush;
    logic [WW-1:0]    word_out;
    logic [2:0]       word_bytes;
    logic             word_valid;
    logic             word_ready;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] fq[$];        // upstream FIFO contents
    logic [WIDTH-1:0] popped_q[$];  // popped bytes not yet seen in an emitted word
    logic [WW-1:0]    words_log[$];
    logic [2:0]       bytes_log[$];
    int               words_seen   = 0;
    int               rd_cycles    = 0;
    int               valid_cycles = 0;
    int               cyc          = 0;
    int               rd_first     = -1;
    int               rd_last      = -1;
    logic             held         = 1'b0;
    logic [WW-1:0]    held_word    = '0;
    logic [2:0]       held_bytes   = 3'd0;
    logic             flush_since  = 1'b0;
    int               w0;
    int               stall;

    fifo_word_packer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .flush      (flush),
        .word_out   (word_out),
        .word_bytes (word_bytes),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] logged_word(input int back);
        if (words_log.size() > back) return words_log[words_log.size() - 1 - back];
        else return '0;
    endfunction

    function automatic logic [2:0] logged_bytes(input int back);
        if (bytes_log.size() > back) return bytes_log[bytes_log.size() - 1 - back];
        else return 3'd0;
    endfunction

    // One clock cycle. The task is entered at a negedge: it drives the inputs,
    // checks the outputs, models the FIFO pop, and returns at the next negedge.
    task automatic cycle(input logic flush_v, input logic ready_v, input logic gap_v);
        logic             popped;
        logic [WIDTH-1:0] b;
        logic [WW-1:0]    exp_w;
        logic [2:0]       exp_b;
        int               n;
        popped = 1'b0;
        b      = '0;
        exp_w  = '0;
        exp_b  = 3'd0;
        n      = 0;
        flush      = flush_v;
        word_ready = ready_v;
        fifo_empty = (fq.size() == 0) || gap_v;
        #1;
        if (held) begin
            check_eq("hold_valid", 64'(word_valid), 64'(1));
            check_eq("hold_word", 64'(word_out), 64'(held_word));
            check_eq("hold_bytes", 64'(word_bytes), 64'(held_bytes));
        end
        check_eq("rd_in_out", 64'(fifo_rd & word_valid), 64'(0));
        check_eq("rd_on_empty", 64'(fifo_rd & fifo_empty), 64'(0));
        if (word_valid && !held) begin
            n = popped_q.size();
            check_eq("word_overfill", 64'(n > LANES), 64'(0));
            for (int k = 0; k < n && k < LANES; k++) exp_w[k*WIDTH +: WIDTH] = popped_q[k];
            exp_b = flush_since ? 3'(n) : 3'(LANES);
            check_eq("word_out", 64'(word_out), 64'(exp_w));
            check_eq("word_bytes", 64'(word_bytes), 64'(exp_b));
            words_log.push_back(word_out);
            bytes_log.push_back(word_bytes);
            for (int k = 0; k < n && k < LANES; k++) void'(popped_q.pop_front());
            words_seen++;
            flush_since = 1'b0;
            held_word   = exp_w;
            held_bytes  = exp_b;
        end
        held = word_valid && !ready_v;
        if (flush_v && !word_valid) flush_since = 1'b1;
        if (word_valid) valid_cycles++;
        if (fifo_rd) begin
            rd_cycles++;
            if (rd_first < 0) rd_first = cyc;
            rd_last = cyc;
        end
        if (fifo_rd && !fifo_empty && (fq.size() > 0)) begin
            popped = 1'b1;
            b = fq.pop_front();
            popped_q.push_back(b);
        end
        @(posedge clk);
        #1;
        fifo_data = popped ? b : WIDTH'($urandom);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_window();
        w0           = words_seen;
        rd_cycles    = 0;
        valid_cycles = 0;
        rd_first     = -1;
        rd_last      = -1;
    endtask

    initial begin
        rst        = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = '0;
        flush      = 1'b0;
        word_ready = 1'b0;

        // Reset state: fifo_rd must be low under reset even though the FIFO is not empty.
        @(negedge clk);
        #1;
        check_eq("reset_word", 64'(word_out), 64'(0));
        check_eq("reset_bytes", 64'(word_bytes), 64'(0));
        check_eq("reset_valid", 64'(word_valid), 64'(0));
        check_eq("reset_rd", 64'(fifo_rd), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Four bytes, sink always ready.
        start_window();
        fq = '{8'd10, 8'd20, 8'd30, 8'd40};
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("a_rd_cycles", 64'(rd_cycles), 64'(4));
        check_eq("a_rd_consec", 64'(rd_last - rd_first), 64'(3));
        check_eq("a_valid_cycles", 64'(valid_cycles), 64'(1));
        check_eq("a_words", 64'(words_seen - w0), 64'(1));
        check_eq("a_word", 64'(logged_word(0)), 64'h281E140A);
        check_eq("a_bytes", 64'(logged_bytes(0)), 64'(4));

        // Eight bytes. The sink stalls for 5 cycles on the first word.
        start_window();
        stall = 0;
        for (int i = 1; i <= 8; i++) fq.push_back(WIDTH'(i));
        for (int i = 0; i < 40; i++) begin
            logic r;
            r = 1'b1;
            if (word_valid && (stall < 5)) begin
                r = 1'b0;
                stall++;
            end
            cycle(1'b0, r, 1'b0);
        end
        check_eq("b_words", 64'(words_seen - w0), 64'(2));
        check_eq("b_valid_cycles", 64'(valid_cycles), 64'(7));
        check_eq("b_word1", 64'(logged_word(1)), 64'h04030201);
        check_eq("b_word2", 64'(logged_word(0)), 64'h08070605);

        // Three bytes, then the FIFO runs dry and a flush pulse is sent.
        start_window();
        fq = '{8'd50, 8'd60, 8'd70};
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("c_no_word_yet", 64'(words_seen - w0), 64'(0));
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("c_words", 64'(words_seen - w0), 64'(1));
        check_eq("c_word", 64'(logged_word(0)), 64'h00463C32);
        check_eq("c_bytes", 64'(logged_bytes(0)), 64'(3));

        // Flush arrives in the same cycle as the second pop. Then a flush is sent with nothing captured.
        start_window();
        fq = '{8'h5A, 8'h6B};
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("d_first_pop", 64'(rd_cycles), 64'(1));
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("d_second_pop", 64'(rd_cycles), 64'(2));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("d_words", 64'(words_seen - w0), 64'(1));
        check_eq("d_word", 64'(logged_word(0)), 64'h00006B5A);
        check_eq("d_bytes", 64'(logged_bytes(0)), 64'(2));
        start_window();
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("d_empty_flush_words", 64'(words_seen - w0), 64'(0));
        check_eq("d_empty_flush_valid", 64'(valid_cycles), 64'(0));

        // FIFO empty flag alternates every cycle.
        start_window();
        fq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'((i % 2) == 1));
        check_eq("e_words", 64'(words_seen - w0), 64'(1));
        check_eq("e_word", 64'(logged_word(0)), 64'hDDCCBBAA);

        // Reset in the middle of a word. The captured bytes must be discarded.
        start_window();
        fq = '{8'h91, 8'h92};
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("f_partial", 64'(word_out), 64'h00009291);
        fifo_empty = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("f_rst_word", 64'(word_out), 64'(0));
        check_eq("f_rst_bytes", 64'(word_bytes), 64'(0));
        check_eq("f_rst_valid", 64'(word_valid), 64'(0));
        check_eq("f_rst_rd", 64'(fifo_rd), 64'(0));
        popped_q.delete();
        held        = 1'b0;
        flush_since = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0);
        check_eq("f_words", 64'(words_seen - w0), 64'(1));
        check_eq("f_word", 64'(logged_word(0)), 64'h44332211);

        // Randomized traffic: FIFO gaps, sink backpressure and random flushes.
        start_window();
        for (int i = 0; i < 400; i++) begin
            if ((fq.size() < 6) && ($urandom_range(1, 0) == 1)) fq.push_back(WIDTH'($urandom));
            cycle(1'($urandom_range(19, 0) == 0), 1'($urandom_range(9, 0) < 6),
                  1'($urandom_range(9, 0) < 3));
        end
        for (int i = 0; i < 300; i++) begin
            if ((fq.size() == 0) && (popped_q.size() == 0) && !word_valid) break;
            cycle(1'(fq.size() == 0), 1'b1, 1'b0);
        end
        check_eq("rand_drain_popped", 64'(popped_q.size()), 64'(0));
        check_eq("rand_drain_fifo", 64'(fq.size()), 64'(0));
        check_eq("rand_some_words", 64'((words_seen - w0) > 20), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the byte width of each FIFO entry.
REQ-002 SHALL have parameter LANES, default 4, meaning the number of FIFO entries packed into one output word.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port fifo_empty  input  1  meaning the upstream synchronous FIFO `empty` flag.
REQ-006 SHALL have port fifo_data  input  WIDTH  meaning the upstream FIFO `data_out`, valid one cycle after a pop.
REQ-007 SHALL have port fifo_rd  output  1  meaning the pop request to the upstream FIFO `rd`.
REQ-008 SHALL have port flush  input  1  meaning a one-cycle request to emit a partially filled word.
REQ-009 SHALL have port word_out  output  WIDTH*LANES  meaning the packed output word.
REQ-010 SHALL have port word_bytes  output  3  meaning the number of valid lanes in word_out (1..LANES).
REQ-011 SHALL have port word_valid  output  1  meaning word_out and word_bytes are valid.
REQ-012 SHALL have port word_ready  input  1  meaning the downstream sink accepts the word.

Function
REQ-013 SHALL implement a two-state FSM: FILL (collecting bytes) and OUT (holding a word for handshake).
REQ-014 SHALL treat the FIFO read latency as one cycle: data popped by fifo_rd=1 in cycle N is captured from fifo_data at the rising edge ending cycle N+1.
REQ-015 SHALL track one pending-read flag (pend), set in any cycle with fifo_rd=1 and cleared when that byte is captured; consecutive pops are allowed, so pend may be set and cleared in the same cycle.
REQ-016 SHALL drive fifo_rd combinationally as: state==FILL and fifo_empty==0 and flush_req==0 and (cnt + pend) < LANES.
REQ-017 SHALL store the k-th captured byte of a word (k = 0..LANES-1) in word_out[k*WIDTH +: WIDTH], first byte in the least-significant lane.
REQ-018 SHALL, on capturing the byte that makes cnt == LANES, enter OUT next cycle with word_valid=1 and word_bytes=LANES.
REQ-019 SHALL hold word_out, word_bytes and word_valid stable in OUT until word_valid && word_ready, then clear cnt and all lanes to 0 and return to FILL in the same edge.
REQ-020 SHALL never assert fifo_rd in OUT (no overlap of fill and output).
REQ-021 SHALL latch flush into flush_req, blocking new pops; when pend==0, emit the current word if cnt>0 (word_bytes=cnt, unused lanes 0, enter OUT), or clear flush_req with no output if cnt==0.
REQ-022 SHALL ignore flush while in OUT, and clear flush_req on entering OUT.
REQ-023 SHALL tolerate fifo_empty toggling between pops; gaps only stall packing and never corrupt lane order.
REQ-024 SHALL compute cnt in a counter of ceil(log2(LANES+1)) bits with no wrap-around: cnt never exceeds LANES.

Reset
REQ-025 SHALL, while rst=1, asynchronously force state=FILL, cnt=0, pend=0, flush_req=0, word_out=0, word_bytes=0, word_valid=0; fifo_rd SHALL evaluate to 0.
REQ-026 SHALL on reset mid-word discard all captured bytes and any pending read; the first byte captured after reset occupies lane 0.

Verification
REQ-027 SHALL pass: FIFO holds 10,20,30,40, word_ready=1 -> fifo_rd high 4 consecutive cycles, word_out=0x281E140A, word_bytes=4, word_valid for exactly 1 cycle.
REQ-028 SHALL pass: 8 bytes 1..8 with word_ready=0 for 5 cycles after first valid -> word 0x04030201 held stable 6 cycles, fifo_rd=0 throughout, then word 0x08070605.
REQ-029 SHALL pass: bytes 50,60,70 then fifo_empty=1, flush pulse -> word_out=0x00463C32, word_bytes=3, word_valid=1.
REQ-030 SHALL pass: flush pulse asserted the same cycle the 2nd byte is popped -> pop completes, then word_bytes=2 emitted; flush with cnt=0 -> no word_valid.
REQ-031 SHALL pass: fifo_empty alternating each cycle, bytes 0xAA,0xBB,0xCC,0xDD -> word_out=0xDDCCBBAA.
REQ-032 SHALL pass: rst asserted asynchronously after 2 bytes captured -> all outputs 0 immediately; next 4 bytes 0x11..0x44 produce 0x44332211.
